mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-access stage of the LC-3 pipeline. Consumes the Execute stage's memory-side outputs: IR_Exec, pcout (effective address), M_Data (store data), Mem_Control_out.
- Drives a request/acknowledge data-memory port and returns load data to Writeback.
- Sequences single and indirect accesses (LD/LDR/LDI/ST/STR/STI) with a state machine.
- Stalls upstream while an access is in flight.

Parameters:
- AW, 16, data-memory address width.
- DW, 16, data width.
- TIMEOUT_CYCLES, 15, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ex_valid  in  1  Execute presents an instruction this cycle
- ex_ir  in  16  IR_Exec from Execute
- ex_addr  in  AW  pcout (effective address) from Execute
- ex_mdata  in  DW  M_Data (store value) from Execute
- ex_indirect  in  1  Mem_Control_out: 1 = LDI/STI two-phase access
- ready  out  1  stage can accept; low = stall Execute
- dmem_addr  out  AW  memory address
- dmem_wdata  out  DW  memory write data
- dmem_rd  out  1  read request
- dmem_wr  out  1  write request
- dmem_ack  in  1  memory completion
- dmem_rdata  in  DW  memory read data, valid with dmem_ack
- wb_data  out  DW  load result to Writeback
- wb_valid  out  1  one-cycle pulse: wb_data updated
- st_done  out  1  one-cycle pulse: store completed
- mem_err  out  1  sticky timeout error (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset: state IDLE; ready=1; dmem_rd=dmem_wr=0; dmem_addr=dmem_wdata=0; wb_data=0; wb_valid=st_done=0; mem_err=0.
- All outputs are registered.
- Acceptance: at a posedge with ex_valid && ready, register ex_ir, ex_addr and ex_mdata. Decode the kind from ex_ir[15:12]:
  - LD 0010, LDR 0110: LOAD.
  - ST 0011, STR 0111: STORE.
  - LDI 1010, STI 1011: indirect LOAD/STORE. Treated as indirect only when ex_indirect=1; otherwise handled as the direct form.
  - Any other opcode: accepted, no memory access, no pulses, state stays IDLE.
- States: IDLE, IND, RD, WR.
  - IDLE -> IND (indirect), RD (load), WR (store).
  - IND: dmem_rd=1, dmem_addr=ex_addr. On ack, latch dmem_rdata as the new address, then -> RD (LDI) or -> WR (STI). Request drops for exactly one cycle between phases.
  - RD: dmem_rd=1. On ack, wb_data<=dmem_rdata, wb_valid=1 next cycle, -> IDLE.
  - WR: dmem_wr=1, dmem_wdata=stored M_Data. On ack, st_done=1 next cycle, -> IDLE.
- Latency: request asserts the cycle after acceptance. Ack sampled in the first request cycle completes that cycle (zero wait states).
  - LD: accept at edge N, wb_valid high N+2..N+3.
  - LDI: wb_valid after 2 acks + 1 gap cycle.
- ready=1 only in IDLE. It rises in the same cycle wb_valid or st_done pulses, so back-to-back accesses have a one-cycle bubble.
- Request hold: dmem_rd/dmem_wr and dmem_addr/dmem_wdata stay stable until ack. dmem_rd and dmem_wr are never both high.
- dmem_ack while no request is pending: ignored.
- wb_data holds its value until the next load completes.
- ex_valid while ready=0: ignored; upstream must hold it.
- Reset mid-operation: the next edge forces IDLE and drops the request; a late ack is ignored.
- Address and data are 16-bit; no arithmetic is performed; the indirect pointer is used verbatim.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter counts cycles in IND/RD/WR without ack.
  - Reaching TIMEOUT_CYCLES: drop the request, go to IDLE, set mem_err=1 (sticky until reset).
  - No wb_valid or st_done pulse for the aborted access.
  - The counter clears on every state transition.
- Undefined: no counter; the FSM waits on ack indefinitely; mem_err is constant 0.

Test Plan:
- LD x2002, addr x3000, ack the first request cycle with rdata xBEEF -> dmem_rd for 1 cycle at x3000; wb_valid pulse; wb_data=xBEEF; ready low for exactly 2 cycles.
- STR x7042, addr x4010, mdata x1234, ack after 3 wait cycles -> dmem_wr held 4 cycles, addr x4010, wdata x1234; st_done pulse; no wb_valid.
- LDI xA404, ex_indirect=1, addr x3000:
  - first ack returns x5000, second returns x00AA.
  - Required: read x3000, 1 idle cycle, read x5000; wb_data=x00AA.
- STI xB404, ex_indirect=1, addr x3001, mdata xCAFE; pointer read returns x6000 -> write xCAFE at x6000; rd and wr never overlap.
- ADD x1042 with ex_valid; stray dmem_ack while idle -> no request, no pulses, ready stays 1.
- Reset asserted mid-RD (no ack), then ack next cycle -> outputs return to reset values, no wb_valid. With MEM_TIMEOUT_EN and no ack: mem_err=1 after 15 cycles, request dropped.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-access stage of the LC-3 pipeline.
// Takes the Execute stage's memory-side outputs and runs single or indirect
// loads and stores over a request/acknowledge data-memory port. Load results go
// to Writeback. Execute is stalled (ready low) while an access is in flight.
//
// Build option: define MEM_TIMEOUT_EN to add a watchdog. If an access waits
// TIMEOUT_CYCLES cycles without an ack, it is aborted and the sticky mem_err
// flag is set.
//
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   ex_valid/ex_ir      instruction handshake and IR_Exec from Execute
//   ex_addr/ex_mdata    effective address and store data from Execute
//   ex_indirect         1 = LDI/STI two-phase access
//   ready               stage idle and able to accept
//   dmem_*              data-memory request/acknowledge port
//   wb_data/wb_valid    load result and its one-cycle update pulse
//   st_done             one-cycle pulse when a store completes
//   mem_err             sticky watchdog error (always 0 without MEM_TIMEOUT_EN)
module mem_access_ctrl #(
    parameter int unsigned AW             = 16,
    parameter int unsigned DW             = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ex_valid,
    input  logic [15:0]   ex_ir,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_mdata,
    input  logic          ex_indirect,
    output logic          ready,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic          dmem_rd,
    output logic          dmem_wr,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic [DW-1:0] wb_data,
    output logic          wb_valid,
    output logic          st_done,
    output logic          mem_err
);

    typedef enum logic [1:0] {StIdle, StInd, StRd, StWr} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;      // target address (pointer after the IND phase)
    logic [DW-1:0] mdata_q, mdata_d;
    logic          store_q, store_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          wb_valid_q, wb_valid_d;
    logic          st_done_q, st_done_d;
    logic          ready_q, ready_d;
    logic          ack_hit;

    // Only the opcode field of the IR matters here.
    logic unused_ir;
    assign unused_ir = ^ex_ir[11:0];

    // An ack counts only while a request is actually on the port.
    assign ack_hit = dmem_ack && (rd_q || wr_q);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mdata_d    = mdata_q;
        store_d    = store_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        st_done_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif

        case (state_q)
            StIdle: begin
                if (ex_valid && ready_q) begin
                    addr_d  = ex_addr;
                    mdata_d = ex_mdata;
                    case (ex_ir[15:12])
                        4'b0010, 4'b0110: begin
                            store_d = 1'b0;
                            state_d = StRd;
                        end
                        4'b0011, 4'b0111: begin
                            store_d = 1'b1;
                            state_d = StWr;
                        end
                        // LDI/STI fall back to the direct form without ex_indirect.
                        4'b1010: begin
                            store_d = 1'b0;
                            state_d = ex_indirect ? StInd : StRd;
                        end
                        4'b1011: begin
                            store_d = 1'b1;
                            state_d = ex_indirect ? StInd : StWr;
                        end
                        default: ;
                    endcase
                end
            end
            StInd: begin
                if (ack_hit) begin
                    // Pointer used verbatim; request drops for one cycle here.
                    addr_d  = AW'(dmem_rdata);
                    state_d = store_q ? StWr : StRd;
                end else begin
                    rd_d    = 1'b1;
                    maddr_d = addr_q;
                end
            end
            StRd: begin
                if (ack_hit) begin
                    wb_data_d  = dmem_rdata;
                    wb_valid_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    rd_d    = 1'b1;
                    maddr_d = addr_q;
                end
            end
            StWr: begin
                if (ack_hit) begin
                    st_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wr_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = mdata_q;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef MEM_TIMEOUT_EN
        if (state_q == StIdle || state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                state_d = StIdle;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                err_d   = 1'b1;
                cnt_d   = '0;
            end
        end
`endif

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            mdata_q    <= '0;
            store_q    <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            ready_q    <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mdata_q    <= mdata_d;
            store_q    <= store_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            st_done_q  <= st_done_d;
            ready_q    <= ready_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign dmem_addr  = maddr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_rd    = rd_q;
    assign dmem_wr    = wr_q;
    assign wb_data    = wb_data_q;
    assign wb_valid   = wb_valid_q;
    assign st_done    = st_done_q;
`ifdef MEM_TIMEOUT_EN
    assign mem_err    = err_q;
`else
    assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed, self-checking bench for mem_access_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The control vector is {ready, dmem_rd, dmem_wr, wb_valid, st_done}.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [15:0] ex_ir;
    logic [15:0] ex_addr;
    logic [15:0] ex_mdata;
    logic        ex_indirect;
    logic        ready;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_rd;
    logic        dmem_wr;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic [15:0] wb_data;
    logic        wb_valid;
    logic        st_done;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(
        .AW(16),
        .DW(16),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ir      (ex_ir),
        .ex_addr    (ex_addr),
        .ex_mdata   (ex_mdata),
        .ex_indirect(ex_indirect),
        .ready      (ready),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .st_done    (st_done),
        .mem_err    (mem_err)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [15:0] ir, input logic [15:0] addr,
                           input logic [15:0] mdata, input logic ind);
        ex_valid    = 1'b1;
        ex_ir       = ir;
        ex_addr     = addr;
        ex_mdata    = mdata;
        ex_indirect = ind;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; ex_ir = '0; ex_addr = '0; ex_mdata = '0;
        ex_indirect = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) step();
        reset = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, mem_err, dmem_addr, dmem_wdata, wb_data}
            !== {6'b100000, 48'h0}) begin
            errors++;
            $display("FAIL reset_vals: got %b %h %h %h want 100000 0000 0000 0000",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done, mem_err},
                     dmem_addr, dmem_wdata, wb_data);
        end
        step();
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_idle: got %b want 10000",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done});
        end
    endtask

    // LD, acked in the first request cycle.
    task automatic test_ld();
        present(16'h2002, 16'h3000, 16'h0000, 1'b0);
        step();
        ex_valid = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done} !== 5'b00000) begin
            errors++;
            $display("FAIL ld_accept: got %b want 00000", {ready, dmem_rd, dmem_wr, wb_valid, st_done});
        end
        step();
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, dmem_addr} !== {5'b01000, 16'h3000}) begin
            errors++;
            $display("FAIL ld_req: got %b %h want 01000 3000",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done}, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, wb_data} !== {5'b10010, 16'hBEEF}) begin
            errors++;
            $display("FAIL ld_done: got %b %h want 10010 beef",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done}, wb_data);
        end
        step();
        checks++;
        if ({ready, dmem_rd, wb_valid, wb_data} !== {3'b100, 16'hBEEF}) begin
            errors++;
            $display("FAIL ld_after: got %b %h want 100 beef", {ready, dmem_rd, wb_valid}, wb_data);
        end
    endtask

    // STR, acked in the fourth request cycle.
    task automatic test_store();
        present(16'h7042, 16'h4010, 16'h1234, 1'b0);
        step();
        ex_valid = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr} !== 3'b000) begin
            errors++;
            $display("FAIL st_accept: got %b want 000", {ready, dmem_rd, dmem_wr});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ready, dmem_rd, dmem_wr, dmem_addr, dmem_wdata} !== {3'b001, 16'h4010, 16'h1234}) begin
                errors++;
                $display("FAIL st_hold%0d: got %b %h %h want 001 4010 1234", i,
                         {ready, dmem_rd, dmem_wr}, dmem_addr, dmem_wdata);
            end
            dmem_ack = (i == 3);
        end
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done} !== 5'b10001) begin
            errors++;
            $display("FAIL st_done: got %b want 10001", {ready, dmem_rd, dmem_wr, wb_valid, st_done});
        end
        step();
        checks++;
        if ({st_done, wb_valid, dmem_wr} !== 3'b000) begin
            errors++;
            $display("FAIL st_pulse: got %b want 000", {st_done, wb_valid, dmem_wr});
        end
    endtask

    task automatic test_ldi();
        present(16'hA404, 16'h3000, 16'h0000, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        checks++;
        if ({dmem_rd, dmem_wr, dmem_addr} !== {2'b10, 16'h3000}) begin
            errors++;
            $display("FAIL ldi_ptr_req: got %b %h want 10 3000", {dmem_rd, dmem_wr}, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h5000;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, wb_data} !== {4'b0000, 16'hBEEF}) begin
            errors++;
            $display("FAIL ldi_gap: got %b %h want 0000 beef", {ready, dmem_rd, dmem_wr, wb_valid}, wb_data);
        end
        step();
        checks++;
        if ({dmem_rd, dmem_wr, dmem_addr} !== {2'b10, 16'h5000}) begin
            errors++;
            $display("FAIL ldi_data_req: got %b %h want 10 5000", {dmem_rd, dmem_wr}, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h00AA;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, wb_valid, wb_data} !== {3'b101, 16'h00AA}) begin
            errors++;
            $display("FAIL ldi_done: got %b %h want 101 00aa", {ready, dmem_rd, wb_valid}, wb_data);
        end
        step();
    endtask

    task automatic test_sti();
        present(16'hB404, 16'h3001, 16'hCAFE, 1'b1);
        step();
        ex_valid = 1'b0;
        step();
        checks++;
        if ({dmem_rd, dmem_wr, dmem_addr} !== {2'b10, 16'h3001}) begin
            errors++;
            $display("FAIL sti_ptr_req: got %b %h want 10 3001", {dmem_rd, dmem_wr}, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h6000;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr} !== 3'b000) begin
            errors++;
            $display("FAIL sti_gap: got %b want 000", {ready, dmem_rd, dmem_wr});
        end
        step();
        checks++;
        if ({dmem_rd, dmem_wr, dmem_addr, dmem_wdata} !== {2'b01, 16'h6000, 16'hCAFE}) begin
            errors++;
            $display("FAIL sti_write: got %b %h %h want 01 6000 cafe", {dmem_rd, dmem_wr},
                     dmem_addr, dmem_wdata);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, wb_data} !== {5'b10001, 16'h00AA}) begin
            errors++;
            $display("FAIL sti_done: got %b %h want 10001 00aa",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done}, wb_data);
        end
        step();
    endtask

    // ADD is accepted without any memory activity; a stray ack is ignored.
    task automatic test_nonmem();
        present(16'h1042, 16'h1111, 16'h2222, 1'b0);
        step();
        ex_valid = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, wb_data} !== {5'b10000, 16'h00AA}) begin
                errors++;
                $display("FAIL nonmem%0d: got %b %h want 10000 00aa", i,
                         {ready, dmem_rd, dmem_wr, wb_valid, st_done}, wb_data);
            end
            step();
        end
        dmem_ack = 1'b0;
    endtask

    // LDI opcode without ex_indirect behaves as a plain LD.
    task automatic test_ldi_direct();
        present(16'hA404, 16'h3100, 16'h0000, 1'b0);
        step();
        ex_valid = 1'b0;
        step();
        checks++;
        if ({dmem_rd, dmem_addr} !== {1'b1, 16'h3100}) begin
            errors++;
            $display("FAIL ldi_direct_req: got %b %h want 1 3100", dmem_rd, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h1111;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, wb_valid, wb_data} !== {3'b101, 16'h1111}) begin
            errors++;
            $display("FAIL ldi_direct_done: got %b %h want 101 1111", {ready, dmem_rd, wb_valid}, wb_data);
        end
        step();
        checks++;
        if ({ready, dmem_rd} !== 2'b10) begin
            errors++;
            $display("FAIL ldi_direct_no2nd: got %b want 10", {ready, dmem_rd});
        end
    endtask

    // Held ex_valid is ignored while busy and accepted as ready rises.
    task automatic test_back_to_back();
        present(16'h2002, 16'h0100, 16'h0000, 1'b0);
        step();
        present(16'h3000, 16'h0200, 16'h5555, 1'b0);
        step();
        checks++;
        if ({dmem_rd, dmem_wr, dmem_addr} !== {2'b10, 16'h0100}) begin
            errors++;
            $display("FAIL b2b_ld_req: got %b %h want 10 0100", {dmem_rd, dmem_wr}, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h7777;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, wb_valid, wb_data} !== {2'b11, 16'h7777}) begin
            errors++;
            $display("FAIL b2b_ld_done: got %b %h want 11 7777", {ready, wb_valid}, wb_data);
        end
        step();
        ex_valid = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_st_accept: got %b want 0000", {ready, dmem_rd, dmem_wr, wb_valid});
        end
        step();
        checks++;
        if ({dmem_wr, dmem_addr, dmem_wdata} !== {1'b1, 16'h0200, 16'h5555}) begin
            errors++;
            $display("FAIL b2b_st_req: got %b %h %h want 1 0200 5555", dmem_wr, dmem_addr, dmem_wdata);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, st_done} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_st_done: got %b want 11", {ready, st_done});
        end
        step();
    endtask

    task automatic test_reset_mid();
        present(16'h2002, 16'h0300, 16'h0000, 1'b0);
        step();
        ex_valid = 1'b0;
        step();
        checks++;
        if (dmem_rd !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req: got %b want 1", dmem_rd);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({ready, dmem_rd, dmem_wr, wb_valid, st_done, mem_err, dmem_addr, dmem_wdata, wb_data}
            !== {6'b100000, 48'h0}) begin
            errors++;
            $display("FAIL rst_mid_vals: got %b %h %h %h want 100000 0000 0000 0000",
                     {ready, dmem_rd, dmem_wr, wb_valid, st_done, mem_err},
                     dmem_addr, dmem_wdata, wb_data);
        end
        dmem_ack = 1'b1; dmem_rdata = 16'h9999;
        step();
        dmem_ack = 1'b0;
        checks++;
        if ({ready, dmem_rd, wb_valid, wb_data} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL rst_mid_late_ack: got %b %h want 100 0000", {ready, dmem_rd, wb_valid}, wb_data);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        present(16'h2002, 16'h0400, 16'h0000, 1'b0);
        step();
        ex_valid = 1'b0;
        n = 0;
        while (mem_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want 15", n);
        end
        checks++;
        if ({ready, dmem_rd, wb_valid, mem_err} !== 4'b1001) begin
            errors++;
            $display("FAIL timeout_abort: got %b want 1001", {ready, dmem_rd, wb_valid, mem_err});
        end
        step();
        step();
        checks++;
        if ({mem_err, wb_valid} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_sticky: got %b want 10", {mem_err, wb_valid});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ld();
        test_store();
        test_ldi();
        test_sti();
        test_nonmem();
        test_ldi_direct();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL mem_err_tied: got %b want 0", mem_err);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
